// File: rtl/exu_muldiv_seq.sv
// exu_muldiv_seq: iterative RV M-extension multiply/divide unit with valid/ready handshakes and flush.
// Define EXU_MULDIV_EARLY_EN to let trivial operand cases skip the iteration loop.
module exu_muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opd_q, opd_d, src1_q, src1_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d, rneg_q, rneg_d, div0_q, div0_d;
    logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;

    logic              sgn1, sgn2, s1neg, s2neg, in_div0, early;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] acc_init, mul_next, div_next, prod;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [XLEN-1:0]   qv, rv, fix_res;

    assign sgn1     = in_op[2] ? ~in_op[0] : (in_op == 3'd1 || in_op == 3'd2);
    assign sgn2     = in_op[2] ? ~in_op[0] : (in_op == 3'd1);
    assign s1neg    = sgn1 & in_src1[XLEN-1];
    assign s2neg    = sgn2 & in_src2[XLEN-1];
    assign mag_a    = s1neg ? -in_src1 : in_src1;
    assign mag_b    = s2neg ? -in_src2 : in_src2;
    assign in_div0  = in_op[2] & (in_src2 == {XLEN{1'b0}});

`ifdef EXU_MULDIV_EARLY_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    logic ovf;
    assign ovf   = sgn1 && in_src1 == MIN_NEG && in_src2 == {XLEN{1'b1}};
    assign early = in_op[2] ? (in_div0 || ovf || mag_a < mag_b)
                            : (in_src1 == {XLEN{1'b0}} || in_src2 == {XLEN{1'b0}});
`else
    assign early = 1'b0;
`endif

    // Early-out cases preload the accumulator with the final magnitudes so FIX stays generic.
    assign acc_init = in_op[2] ? ((early && mag_a < mag_b) ? {mag_a, {XLEN{1'b0}}} : {{XLEN{1'b0}}, mag_a})
                               : (early ? {2*XLEN{1'b0}} : {{XLEN{1'b0}}, mag_b});

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = div_sh - {1'b0, opd_q};
    assign div_next = {div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0], acc_q[XLEN-2:0], ~div_diff[XLEN]};

    assign prod    = neg_q ? -acc_q : acc_q;
    assign qv      = div0_q ? {XLEN{1'b1}} : (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    assign rv      = div0_q ? src1_q : (rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN]);
    assign fix_res = op_q[2] ? (op_q[1] ? rv : qv)
                             : (op_q == 3'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        opd_d        = opd_q;
        src1_d       = src1_q;
        acc_d        = acc_q;
        neg_d        = neg_q;
        rneg_d       = rneg_q;
        div0_d       = div0_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        if (flush) begin
            state_d = IDLE;
        end else if (state_q == IDLE && in_valid && in_ready_q) begin
            state_d   = early ? FIX : CALC;
            cnt_d     = '0;
            op_d      = in_op;
            opd_d     = in_op[2] ? mag_b : mag_a;
            src1_d    = in_src1;
            acc_d     = acc_init;
            neg_d     = s1neg ^ s2neg;
            rneg_d    = s1neg;
            div0_d    = in_div0;
            out_tag_d = in_tag;
        end else if (state_q == CALC) begin
            acc_d = op_q[2] ? div_next : mul_next;
            cnt_d = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(XLEN-1)) ? FIX : CALC;
        end else if (state_q == FIX) begin
            out_result_d = fix_res;
            state_d      = DONE;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
        in_ready_d  = state_d == IDLE;
        out_valid_d = state_d == DONE;
        busy_d      = state_d == CALC || state_d == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            opd_q        <= '0;
            src1_q       <= '0;
            acc_q        <= '0;
            neg_q        <= 1'b0;
            rneg_q       <= 1'b0;
            div0_q       <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            opd_q        <= opd_d;
            src1_q       <= src1_d;
            acc_q        <= acc_d;
            neg_q        <= neg_d;
            rneg_q       <= rneg_d;
            div0_q       <= div0_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
endmodule

// File: doc/exu_muldiv_seq.md
Name: exu_muldiv_seq

Overview:
- Parametrised multi-cycle execute sub-unit for the NPC core. Implements the RV M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) iteratively.
- Sits beside the single-cycle ALU in the EXU. The EXU routes M-ops here and stalls the core via valid/ready handshakes until the result returns.
- Generalises the ALU datapath to XLEN-wide operands and adds a registered, stall-capable, flushable interface.

Parameters:
- XLEN, 32: operand and result width in bits; legal values 32 and 64.
- TAG_W, 5: width of the destination-register tag carried through the unit unchanged.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- in_op  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_src1  input  XLEN  rs1 operand.
- in_src2  input  XLEN  rs2 operand.
- in_tag  input  TAG_W  destination tag.
- flush  input  1  abort any in-flight op.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  XLEN  result.
- out_tag  output  TAG_W  tag of the result.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (async, on rst high): state=IDLE; in_ready=1; out_valid=0; out_result=0; out_tag=0; busy=0; iteration counter=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch op, tag and operands; compute absolute values per signedness; go to CALC with counter=0.
  - CALC: one iteration per cycle. Multiply: shift-add on a 2*XLEN accumulator. Divide: restoring, one quotient bit per cycle. When counter==XLEN-1, go to FIX.
  - FIX: one cycle; apply sign correction and select the high/low half or quotient/remainder into out_result; go to DONE.
  - DONE: out_valid=1. Hold out_result and out_tag stable until out_valid&&out_ready, then go to IDLE.
- Latency: accept at cycle 0 -> out_valid first high at cycle XLEN+2 (34 for XLEN=32).
- Throughput: no new accept while busy. in_ready=0 outside IDLE; no bypass from DONE to accept.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU / DIVU / REMU: unsigned.
  - MUL: low XLEN bits of the product, independent of signedness.
- Divide corner cases (result fixed by FIX, iteration count unchanged):
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (dividend=-2^(XLEN-1), divisor=-1): DIV = dividend; REM = 0.
  - Remainder sign follows the dividend; quotient truncates toward zero.
- Flush:
  - In any state, flush=1 at a clock edge -> next state IDLE, out_valid=0, result discarded.
  - flush has priority over a simultaneous in_valid accept and over an out_ready handshake.
- Output is registered only; no combinational path from in_* to out_*.
- rst asserted mid-operation: immediate return to reset values; no partial output.

Optional Feature:
- Macro EXU_MULDIV_EARLY_EN.
- When defined: FIX is entered directly from IDLE on accept (latency 2 cycles) for:
  - divisor==0;
  - signed overflow;
  - MUL/MULH*/MULHU with either operand 0;
  - DIV/DIVU/REM/REMU with |src1| < |src2| (quotient 0, remainder = src1).
- When undefined: every op takes exactly XLEN+2 cycles. Results are identical in both builds; only latency differs.

Test Plan:
- MUL 7*-3 (0x00000007, 0xFFFFFFFD), tag 5 -> out_result 0xFFFFFFEB, out_tag 5, out_valid at cycle 34.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_result/out_tag stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
- Flush at cycle 10 of a DIV -> out_valid never asserts. A new MUL 3*4 accepted next cycle -> 12.
- rst pulsed during CALC -> out_valid=0 and in_ready=1 immediately. With EXU_MULDIV_EARLY_EN, DIVU 5/0 -> result 0xFFFFFFFF at cycle 2.
